// File: rtl/matrix_feeder.sv
// matrix_feeder
//   Source-side operand responder for the systolic-array TOP port. Holds one
//   ROWS x COLS matrix A and one matrix B loaded by a host, issues a one-cycle
//   data_valid kick once armed, then answers each read_data request with the
//   next A/B element pair one cycle later.
//
//   Optional feature macro: MATRIX_FEEDER_TRANSPOSE_B_EN
//     defined   : B is served column-major (addr = (i % COLS)*ROWS + i / COLS)
//     undefined : A and B are both served row-major at address ptr
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   wr_en         in   host write strobe (accepted only while EMPTY)
//   wr_sel        in   0 = matrix A, 1 = matrix B
//   wr_addr       in   row-major element index
//   wr_data       in   element value
//   load_go       in   both matrices loaded, arm the feeder
//   read_data     in   element request from TOP
//   start_compute in   rewind read pointer (replay)
//   done          in   TOP finished, release buffer
//   data_valid    out  one-cycle start pulse to TOP
//   data_in_A     out  registered A element (0 when out_valid is 0)
//   data_in_B     out  registered B element (0 when out_valid is 0)
//   out_valid     out  data_in_A/data_in_B carry a requested element
//   busy          out  state is not EMPTY
//   err           out  sticky protocol-error flag, cleared only by rst
module matrix_feeder #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  localparam int DEPTH      = ROWS * COLS,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  load_go,
  input  logic                  read_data,
  input  logic                  start_compute,
  input  logic                  done,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_in_A,
  output logic [DATA_WIDTH-1:0] data_in_B,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {EMPTY, ARMED, STREAM, DRAINED} state_t;

  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_a [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b [DEPTH];

  state_t                state, state_n;
  logic [AW-1:0]         ptr, ptr_n;
  logic [AW-1:0]         b_addr;
  logic                  addr_ok;
  logic                  dv_n, ov_n, err_n;
  logic [DATA_WIDTH-1:0] a_n, b_n;

  assign addr_ok = ({1'b0, wr_addr} < DEPTH_W);
  assign busy    = (state != EMPTY);

`ifdef MATRIX_FEEDER_TRANSPOSE_B_EN
  always_comb begin
    b_addr = AW'(((int'(ptr) % COLS) * ROWS) + (int'(ptr) / COLS));
  end
`else
  always_comb begin
    b_addr = ptr;
  end
`endif

  // Operand storage: host writes only while EMPTY; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state == EMPTY) && addr_ok) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      ptr        <= '0;
      data_valid <= 1'b0;
      out_valid  <= 1'b0;
      data_in_A  <= '0;
      data_in_B  <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      data_valid <= dv_n;
      out_valid  <= ov_n;
      data_in_A  <= a_n;
      data_in_B  <= b_n;
      err        <= err_n;
    end
  end

  // Next-state and next-output logic. Priority: done > start_compute > read_data.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    dv_n    = 1'b0;
    ov_n    = 1'b0;
    a_n     = '0;
    b_n     = '0;
    err_n   = err;

    if (wr_en && ((state != EMPTY) || !addr_ok)) err_n = 1'b1;

    unique case (state)
      EMPTY: begin
        if (read_data) err_n = 1'b1;
        if (load_go) begin
          state_n = ARMED;
          dv_n    = 1'b1;
        end
      end
      ARMED, STREAM: begin
        if (start_compute) begin
          state_n = ARMED;
          ptr_n   = '0;
        end else if (read_data) begin
          ov_n = 1'b1;
          a_n  = mem_a[ptr];
          b_n  = mem_b[b_addr];
          if (ptr == LAST_IDX) begin
            ptr_n   = '0;
            state_n = DRAINED;
          end else begin
            ptr_n   = ptr + 1'b1;
            state_n = STREAM;
          end
        end
      end
      DRAINED: begin
        if (start_compute) begin
          state_n = ARMED;
          ptr_n   = '0;
        end else if (read_data) begin
          err_n = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase

    if (done) begin
      if (state != DRAINED) err_n = 1'b1;
      state_n = EMPTY;
      ptr_n   = '0;
      ov_n    = 1'b0;
      a_n     = '0;
      b_n     = '0;
    end
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// tb_matrix_feeder
//   Directed bench for matrix_feeder (4x4, 8-bit). Inputs change 1 time unit
//   after each rising edge; outputs are checked at that same point, so each
//   check observes the result of the edge just taken.
module tb_matrix_feeder;

  localparam int DW = 8;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, wr_sel, load_go, read_data, start_compute, done;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          data_valid, out_valid, busy, err;
  logic [DW-1:0] data_in_A, data_in_B;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_feeder #(.DATA_WIDTH(DW), .ROWS(4), .COLS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .load_go       (load_go),
    .read_data     (read_data),
    .start_compute (start_compute),
    .done          (done),
    .data_valid    (data_valid),
    .data_in_A     (data_in_A),
    .data_in_B     (data_in_B),
    .out_valid     (out_valid),
    .busy          (busy),
    .err           (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value served on data_in_B for stream index i, with B[k] = 16-k loaded.
  function automatic int exp_b(input int i);
`ifdef MATRIX_FEEDER_TRANSPOSE_B_EN
    return 16 - ((i % 4) * 4 + i / 4);
`else
    return 16 - i;
`endif
  endfunction

  task automatic chk_elem(input string tag, input int i);
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_a"},  32'(data_in_A), 32'(i + 1));
    chk({tag, "_b"},  32'(data_in_B), 32'(exp_b(i)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_a"},  32'(data_in_A), 32'd0);
    chk({tag, "_b"},  32'(data_in_B), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic arm();
    load_go = 1'b1;
    tick();
    load_go = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    load_go = 1'b0; read_data = 1'b0; start_compute = 1'b0; done = 1'b0;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dv",   32'(data_valid), 32'd0);
    chk("rst_err",  32'(err), 32'd0);
    chk_idle("rst");

    // Load A[i]=i+1, B[i]=16-i
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i);
      wr_sel = 1'b0; wr_data = 8'(i + 1); tick();
      wr_sel = 1'b1; wr_data = 8'(16 - i); tick();
    end
    wr_en = 1'b0;
    chk("load_err",  32'(err), 32'd0);
    chk("load_busy", 32'(busy), 32'd0);

    // Kick: data_valid one cycle only
    arm();
    chk("kick_dv",   32'(data_valid), 32'd1);
    chk("kick_busy", 32'(busy), 32'd1);
    tick();
    chk("kick_dv_off", 32'(data_valid), 32'd0);

    // load_go outside EMPTY: no pulse, no error
    arm();
    chk("rearm_dv",  32'(data_valid), 32'd0);
    chk("rearm_err", 32'(err), 32'd0);

    // Full back-to-back stream
    read_data = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      chk_elem($sformatf("strm%0d", i), i);
      chk($sformatf("strm%0d_dv", i), 32'(data_valid), 32'd0);
    end
    read_data = 1'b0;
    tick();
    chk_idle("strm_end");
    chk("strm_end_busy", 32'(busy), 32'd1);
    chk("strm_end_err",  32'(err), 32'd0);

    // Replay from DRAINED, then rewind after 5 elements
    start_compute = 1'b1; tick(); start_compute = 1'b0;
    chk("rpl_dv", 32'(data_valid), 32'd0);
    chk_idle("rpl_start");
    read_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_elem($sformatf("rpl5_%0d", i), i);
    end
    read_data = 1'b0;
    start_compute = 1'b1; tick(); start_compute = 1'b0;
    chk_idle("rpl_rewind");
    read_data = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      chk_elem($sformatf("rpl%0d", i), i);
      chk($sformatf("rpl%0d_dv", i), 32'(data_valid), 32'd0);
    end
    read_data = 1'b0;
    tick();
    chk("rpl_err", 32'(err), 32'd0);

    // start_compute together with read_data mid-stream
    start_compute = 1'b1; tick(); start_compute = 1'b0;
    read_data = 1'b1;
    tick(); chk_elem("sc_pre0", 0);
    tick(); chk_elem("sc_pre1", 1);
    start_compute = 1'b1;
    tick();
    start_compute = 1'b0;
    chk_idle("sc_drop");
    tick(); chk_elem("sc_post0", 0);

    // Request gap: alternate cycles, indices stay contiguous
    for (int i = 1; i < N; i++) begin
      read_data = 1'b0; tick(); chk_idle($sformatf("gap_idle%0d", i));
      read_data = 1'b1; tick(); chk_elem($sformatf("gap%0d", i), i);
    end
    read_data = 1'b0;
    tick();
    done = 1'b1; tick(); done = 1'b0;
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_err",  32'(err), 32'd0);

    // Error: write during STREAM is ignored but flagged
    arm();
    read_data = 1'b1;
    tick(); chk_elem("wrs0", 0);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 8'hAA;
    tick(); chk_elem("wrs1", 1);
    wr_en = 1'b0;
    chk("wrs_err", 32'(err), 32'd1);
    for (int i = 2; i < N; i++) begin
      tick();
      chk_elem($sformatf("wrs%0d", i), i);
    end
    read_data = 1'b0;
    tick();

    // Error: read_data in DRAINED
    do_reset();
    chk("rst2_err", 32'(err), 32'd0);
    arm();
    read_data = 1'b1;
    for (int i = 0; i < N; i++) tick();
    chk_elem("drn_last", 15);
    tick();
    read_data = 1'b0;
    chk_idle("drn_rd");
    chk("drn_err",  32'(err), 32'd1);
    chk("drn_busy", 32'(busy), 32'd1);

    // Error: done in ARMED forces EMPTY
    do_reset();
    arm();
    done = 1'b1; tick(); done = 1'b0;
    chk("dna_busy", 32'(busy), 32'd0);
    chk("dna_err",  32'(err), 32'd1);

    // Reset at element 7 aborts; fresh load_go restarts at index 0
    do_reset();
    arm();
    read_data = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk_elem("rst7_pre", 6);
    rst = 1'b1;
    tick();
    rst = 1'b0; read_data = 1'b0;
    chk_idle("rst7");
    chk("rst7_busy", 32'(busy), 32'd0);
    chk("rst7_dv",   32'(data_valid), 32'd0);
    arm();
    chk("rst7_kick", 32'(data_valid), 32'd1);
    read_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_elem($sformatf("rst7_re%0d", i), i);
    end
    read_data = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_feeder.md
# matrix_feeder

Synthesizable source-side responder for the systolic-array `TOP` operand port. It stores one ROWS×COLS operand matrix A and one B. It issues the one-cycle `data_valid` kick that starts `TOP`, then answers each `read_data` request with the next A/B element pair on `data_in_A`/`data_in_B` one cycle later. It replaces behavioural operand feeding so the array can run from a host-loaded buffer.

## Interface
- `DATA_WIDTH`, 8: element width.
- `ROWS`, 4: matrix rows (array HEIGHT).
- `COLS`, 4: matrix columns (array WIDTH).
- `DEPTH`, ROWS*COLS: elements per matrix (derived, do not override).
- `AW`, $clog2(DEPTH): address width (derived).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe.
- `wr_sel`  in  1  0 = write matrix A, 1 = write matrix B.
- `wr_addr`  in  AW  row-major element index.
- `wr_data`  in  DATA_WIDTH  element value.
- `load_go`  in  1  pulse: both matrices loaded, arm the feeder.
- `read_data`  in  1  element request from `TOP`.
- `start_compute`  in  1  rewind pointer (replay).
- `done`  in  1  `TOP` finished, release buffer.
- `data_valid`  out  1  one-cycle start pulse to `TOP`.
- `data_in_A`  out  DATA_WIDTH  A element, registered.
- `data_in_B`  out  DATA_WIDTH  B element, registered.
- `out_valid`  out  1  `data_in_A`/`data_in_B` carry a requested element.
- `busy`  out  1  state ≠ EMPTY.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Storage: two DEPTH×DATA_WIDTH register arrays. Contents are not reset.
- States:
  - EMPTY: writes accepted. `load_go` → ARMED.
  - ARMED: `read_data` → STREAM.
  - STREAM: after the element at index DEPTH-1 is served → DRAINED.
  - DRAINED: `done` → EMPTY.
- Read pointer `ptr` (AW bits) selects the element. Each accepted `read_data` in ARMED/STREAM serves index `ptr`, then `ptr` increments. `ptr` wraps to 0 after DEPTH-1, coinciding with the STREAM→DRAINED transition.
- Write rule: `wr_en` outside EMPTY is ignored and sets `err`. `wr_addr` ≥ DEPTH is ignored and sets `err`.
- Read rule: `read_data` in EMPTY or DRAINED is ignored, sets `err`, and leaves `out_valid` at 0.
- `start_compute` in ARMED/STREAM/DRAINED sets `ptr`=0 and state=ARMED without issuing a new `data_valid`. In EMPTY it has no effect.
- `start_compute` and `read_data` in the same cycle: `start_compute` wins, the request is dropped, and `out_valid` is 0 next cycle.
- `done` in any state other than DRAINED forces EMPTY and sets `err`.
- `load_go` outside EMPTY is ignored, with no error.
- `err` clears only on `rst`.
- Reset: state=EMPTY, `ptr`=0, all outputs 0.
- Reset mid-stream aborts immediately. Outputs read 0 from the next edge.

## Timing
- `load_go` at cycle N → state ARMED and `data_valid`=1 during cycle N+1 only.
- `read_data` sampled high at edge N → `out_valid`=1 with data for index `ptr` during cycle N+1.
- Back-to-back requests are sustained at one element per cycle.
- `data_in_A`/`data_in_B` are 0 whenever `out_valid`=0.
- Read latency is exactly 1 cycle. There is no backpressure.
- A write at edge N is readable by a request at edge N+1 or later. Only reachable across `load_go`, which is at least 2 cycles.

## Configuration
- `MATRIX_FEEDER_TRANSPOSE_B_EN` defined: B is served column-major. The B address for pointer i is (i % COLS)*ROWS + i / COLS. A is unchanged.
- Undefined: A and B are both served row-major at address `ptr`.

## Test plan
- Load A[i]=i+1, B[i]=16-i, pulse `load_go`, then 16 consecutive `read_data` → `data_valid` is a single pulse one cycle after `load_go`. Out pairs are (1,16)…(16,1) on cycles 1..16 after the first request. The state ends in DRAINED with `err`=0.
- Request gap: `read_data` on alternate cycles → `out_valid` alternates, data indices are contiguous, and outputs are 0 on idle cycles.
- Replay: `start_compute` after 5 elements, then 16 reads → the stream restarts at (1,16) with no second `data_valid`. `start_compute` together with `read_data` → no `out_valid` the next cycle.
- Errors: a write in STREAM, `read_data` in DRAINED, and `done` in ARMED → each sets `err`. State and memory do not change, except `done` forces EMPTY.
- `rst` asserted at element 7 → the next cycle has `out_valid`=0, `busy`=0, and `data_valid`=0. A fresh `load_go` then streams from index 0.
- With `MATRIX_FEEDER_TRANSPOSE_B_EN` and B[i]=i → the B sequence is 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
